dma_write_master: RTL and testbench
===================================

# dma_write_master

Write-master stage of the DMA datapath. It accepts one transfer command (start address, length in words), drains that many words from the internal stream FIFO, and issues them as single-word Avalon-MM writes to memory. On completion it raises `wm_done` for one cycle. That pulse is exported from the system as the write-master-done debug signal, which the top level latches onto an LED.

## Interface

Parameters:
- `ADDR_W`, default 32: Avalon-MM byte address width.
- `DATA_W`, default 32: data word width. Must be a power of two and at least 8.
- `LEN_W`, default 16: width of the word-count fields.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `reset_n`, in, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `cmd_valid`, in, 1: a command is presented.
- `cmd_ready`, out, 1: the block can accept a command.
- `cmd_addr`, in, ADDR_W: start byte address of the transfer.
- `cmd_len`, in, LEN_W: number of words to write. Zero is legal.
- `st_valid`, in, 1: a source word is available from the stream FIFO.
- `st_ready`, out, 1: the block accepts the source word this cycle.
- `st_data`, in, DATA_W: the source word.
- `avm_address`, out, ADDR_W: write byte address.
- `avm_write`, out, 1: write request.
- `avm_writedata`, out, DATA_W: write data.
- `avm_byteenable`, out, DATA_W/8: byte enables. Always all ones.
- `avm_waitrequest`, in, 1: slave stall.
- `busy`, out, 1: high from command accept until `wm_done`.
- `wm_done`, out, 1: one-cycle pulse after the last write of a command is accepted.
- `words_written`, out, LEN_W: number of writes completed for the current or most recent command.

## Operation

- **State machine:** IDLE, WRITE, DONE.
- **IDLE:**
  - `cmd_ready`=1 and `busy`=0.
  - On `cmd_valid`&`cmd_ready`, latch the address, load `remaining`=`cmd_len` and `issued`=0, and clear `words_written`.
  - The latched address has its low log2(DATA_W/8) bits forced to 0.
  - If `cmd_len`=0, go to DONE. Otherwise go to WRITE.
- **WRITE:**
  - `cmd_ready`=0 and `busy`=1.
  - There is a one-word holding stage, represented by `avm_write` being high.
  - `st_ready` = (`issued` < `remaining`) & (!`avm_write` | !`avm_waitrequest`).
  - On `st_valid`&`st_ready`:
    - Load `avm_writedata`=`st_data`.
    - Set `avm_write`=1.
    - Set `avm_address` to the current address.
    - Advance the address by DATA_W/8, wrapping modulo 2^ADDR_W.
    - Increment `issued`.
  - While `avm_write`&`avm_waitrequest`, `avm_address` and `avm_writedata` hold stable.
  - A write completes on `avm_write`&!`avm_waitrequest`. Completion increments `words_written`. If no new word is loaded in the same cycle, `avm_write` drops.
  - When a completion brings `words_written` to `cmd_len`, go to DONE.
- **DONE:**
  - Lasts exactly one cycle.
  - `wm_done`=1 and `busy`=1. `words_written` holds the final count.
  - Next state is IDLE.
- **Command during a transfer:** `cmd_valid` outside IDLE is ignored, because `cmd_ready`=0. The command is not lost; the upstream side keeps it pending.
- **Reset:**
  - `reset_n`=0 at any point, including mid-burst, returns to IDLE.
  - All outputs reset to 0 except `cmd_ready`, which resets to 1. This covers `avm_write`, `avm_address`, `avm_writedata`, `st_ready`, `busy`, `wm_done` and `words_written`.
  - `avm_byteenable` is constant all ones.
  - An in-flight command is abandoned and no `wm_done` is produced for it.

## Timing

- **Command accept to first source word:** the command is accepted at edge N. `st_ready` can be high from cycle N+1.
- **Source word to write request:** a word accepted at edge M gives `avm_write`=1 from cycle M+1.
- **Throughput:** 1 word per cycle when `st_valid` is continuous and `avm_waitrequest`=0. A new word is loaded in the same cycle the previous write completes.
- **Last write to done:**
  - Last write accepted at edge K gives `wm_done`=1 in cycle K+1, and the block is back in IDLE with `cmd_ready`=1 at cycle K+2.
  - For a zero-length command accepted at edge N, `wm_done`=1 in cycle N+1.
- **Minimum command-to-done time:** a len=L command with no stalls gives `wm_done` L+2 cycles after the accept edge.
- **Outputs:** all outputs are registered except `st_ready` and `cmd_ready`, which are combinational from state, counters and `avm_waitrequest`.

## Test plan

- **Nominal transfer:**
  - Stimulus: reset, then command addr=0x1000, len=4, continuous stream 0xA0..0xA3, waitrequest=0.
  - Required: writes to 0x1000, 0x1004, 0x1008, 0x100C on 4 consecutive cycles.
  - Required: a single `wm_done` pulse, then `words_written`=4.
- **Slave stalls:**
  - Stimulus: len=3, waitrequest high 2 cycles on every write.
  - Required: address and data held stable during each stall, `st_ready`=0 during the stall, 3 writes completed, one `wm_done`.
- **Source starvation:**
  - Stimulus: len=2, `st_valid` gapped 3 cycles between words.
  - Required: `avm_write` low during the gap and the correct write order.
- **Zero length and unaligned address:**
  - Stimulus: len=0 at addr 0x2003.
  - Required: no `avm_write`, `wm_done` one cycle after accept.
  - Stimulus: len=1 at addr 0x2003.
  - Required: the write goes to 0x2000.
- **Address wrap and busy command:**
  - Stimulus (ADDR_W=32): addr 0xFFFFFFFC, len=2.
  - Required: writes to 0xFFFFFFFC then 0x00000000.
  - Stimulus: `cmd_valid` held asserted during the transfer.
  - Required: `cmd_ready`=0 until DONE has passed.
- **Reset mid-transfer:**
  - Stimulus: `reset_n`=0 after 2 of 5 writes.
  - Required: `avm_write`=0, `busy`=0, `words_written`=0, no `wm_done`.
  - Required: a following len=1 command completes normally.

Source files
------------

// File: rtl/dma_write_master.sv
// rtl/dma_write_master.sv - DMA write master: drains the stream FIFO into single-word Avalon-MM writes
module dma_write_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [DATA_W-1:0]     st_data,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    output logic                  busy,
    output logic                  wm_done,
    output logic [LEN_W-1:0]      words_written
);

    localparam int BYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [LEN_W-1:0]    issued_q, issued_d;
    logic [LEN_W-1:0]    count_q, count_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                cmd_fire;
    logic                st_fire;
    logic                wr_complete;

    // Handshakes: the holding stage can refill in the same cycle its write completes
    always_comb begin
        cmd_ready   = (state_q == S_IDLE);
        wr_complete = wr_q && !avm_waitrequest;
        st_ready    = (state_q == S_WRITE) && (issued_q < remaining_q)
                      && (!wr_q || !avm_waitrequest);
        cmd_fire    = cmd_valid && cmd_ready;
        st_fire     = st_valid && st_ready;
    end

    // Next-state and datapath updates for the IDLE/WRITE/DONE sequence
    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        remaining_d = remaining_q;
        issued_d    = issued_q;
        count_d     = count_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        data_d      = data_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    next_addr_d = cmd_addr & ~ADDR_MASK;
                    remaining_d = cmd_len;
                    issued_d    = '0;
                    count_d     = '0;
                    state_d     = (cmd_len == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (st_fire) begin
                    data_d      = st_data;
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + ADDR_STEP;
                    issued_d    = issued_q + LEN_W'(1);
                    wr_d        = 1'b1;
                end else if (wr_complete) begin
                    wr_d = 1'b0;
                end
                if (wr_complete) begin
                    count_d = count_q + LEN_W'(1);
                    if (count_q + LEN_W'(1) == remaining_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any in-flight command
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            next_addr_q <= '0;
            remaining_q <= '0;
            issued_q    <= '0;
            count_q     <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            remaining_q <= remaining_d;
            issued_q    <= issued_d;
            count_q     <= count_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign avm_address    = addr_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = data_q;
    assign avm_byteenable = '1;
    assign busy           = busy_q;
    assign wm_done        = done_q;
    assign words_written  = count_q;

endmodule

// File: tb/tb_dma_write_master.sv
// tb/tb_dma_write_master.sv - randomized self-checking bench for dma_write_master
module tb_dma_write_master;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_data;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic        busy;
    logic        wm_done;
    logic [15:0] words_written;

    int total;
    int bad;

    dma_write_master #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .st_valid        (st_valid),
        .st_ready        (st_ready),
        .st_data         (st_data),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .wm_done         (wm_done),
        .words_written   (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        st_valid = 1'b0; st_data = '0; avm_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL reset_st_ready got=%b exp=0", st_ready); end
        total++; if (avm_write !== 1'b0) begin bad++; $display("FAIL reset_avm_write got=%b exp=0", avm_write); end
        total++; if (avm_address !== 32'h0) begin bad++; $display("FAIL reset_avm_address got=%h exp=0", avm_address); end
        total++; if (avm_writedata !== 32'h0) begin bad++; $display("FAIL reset_avm_writedata got=%h exp=0", avm_writedata); end
        total++; if (avm_byteenable !== 4'hF) begin bad++; $display("FAIL reset_byteenable got=%h exp=f", avm_byteenable); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (wm_done !== 1'b0) begin bad++; $display("FAIL reset_wm_done got=%b exp=0", wm_done); end
        total++; if (words_written !== 16'h0) begin bad++; $display("FAIL reset_words_written got=%0d exp=0", words_written); end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // One command end to end. Reference model: write i goes to the aligned
    // start address plus 4*i carrying source word i; each write is visible for
    // stall+1 cycles; done follows the last completion by one cycle.
    task automatic run_cmd(input logic [31:0] addr, input int len, input int stall,
                           input int gap, input bit hold_cmd, input int abort_after,
                           input bit fixed_data, input logic [31:0] data_base,
                           input string name);
        logic [31:0] src[$];
        logic [31:0] base;
        logic [31:0] exp_addr;
        logic [31:0] held_addr;
        logic [31:0] held_data;
        int cnt, src_idx, gap_cnt, wait_cnt, comp, hi_cycles, last_comp, done_cycle;
        bit done_seen, abort_now, held;
        base = addr & ~32'h3;
        for (int i = 0; i < len; i++) src.push_back(fixed_data ? data_base + 32'(i) : $urandom);
        cnt = 0; src_idx = 0; gap_cnt = 0; wait_cnt = 0; comp = 0; hi_cycles = 0;
        last_comp = 0; done_cycle = 0; done_seen = 0; abort_now = 0; held = 0;
        held_addr = '0; held_data = '0;

        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = addr; cmd_len = 16'(len);
        st_valid = 1'b0; avm_waitrequest = 1'b0;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s cmd_ready_idle got=%b exp=1", name, cmd_ready); end
        @(posedge clk);
        while (1) begin
            #1; cnt++;
            if (abort_now) reset_n = 1'b0;
            if (!hold_cmd || done_seen) cmd_valid = 1'b0;
            avm_waitrequest = avm_write && (wait_cnt < stall);
            st_valid = (src_idx < len) && (gap_cnt == 0);
            st_data  = (src_idx < len) ? src[src_idx] : $urandom;
            @(negedge clk);

            if (abort_now) begin
                @(posedge clk); #1;
                reset_n = 1'b1; cmd_valid = 1'b0; st_valid = 1'b0; avm_waitrequest = 1'b0;
                @(negedge clk);
                total++; if (avm_write !== 1'b0) begin bad++; $display("FAIL %s abort_avm_write got=%b exp=0", name, avm_write); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s abort_busy got=%b exp=0", name, busy); end
                total++; if (words_written !== 16'h0) begin bad++; $display("FAIL %s abort_words got=%0d exp=0", name, words_written); end
                total++; if (wm_done !== 1'b0 || done_seen) begin bad++; $display("FAIL %s abort_wm_done got=%b seen=%0d exp=0", name, wm_done, done_seen); end
                total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s abort_cmd_ready got=%b exp=1", name, cmd_ready); end
                total++; if (comp != abort_after) begin bad++; $display("FAIL %s abort_writes got=%0d exp=%0d", name, comp, abort_after); end
                return;
            end

            if (done_seen && cnt == done_cycle + 1) begin
                total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s post_cmd_ready got=%b exp=1", name, cmd_ready); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s post_busy got=%b exp=0", name, busy); end
                total++; if (wm_done !== 1'b0) begin bad++; $display("FAIL %s post_wm_done got=%b exp=0", name, wm_done); end
                total++; if (words_written !== 16'(len)) begin bad++; $display("FAIL %s post_words got=%0d exp=%0d", name, words_written, len); end
                total++; if (hi_cycles != len * (stall + 1)) begin bad++; $display("FAIL %s write_cycles got=%0d exp=%0d", name, hi_cycles, len * (stall + 1)); end
                break;
            end

            if (cnt > 300) begin
                bad++; total++;
                $display("FAIL %s timeout got=%0d_writes exp=%0d", name, comp, len);
                break;
            end

            if (held) begin
                total++;
                if (avm_write !== 1'b1 || avm_address !== held_addr || avm_writedata !== held_data) begin
                    bad++;
                    $display("FAIL %s stall_hold got=%b/%h/%h exp=1/%h/%h", name, avm_write, avm_address, avm_writedata, held_addr, held_data);
                end
            end
            if (!done_seen) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy got=%b exp=1 cyc=%0d", name, busy, cnt); end
                total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL %s cmd_ready_busy got=%b exp=0 cyc=%0d", name, cmd_ready, cnt); end
            end
            if (avm_write && avm_waitrequest) begin
                total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL %s st_ready_stall got=%b exp=0", name, st_ready); end
            end
            if (src_idx >= len) begin
                total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL %s st_ready_extra got=%b exp=0", name, st_ready); end
            end
            if (wm_done) begin
                total++; if (done_seen) begin bad++; $display("FAIL %s double_done got=1 exp=0 cyc=%0d", name, cnt); end
                done_seen = 1; done_cycle = cnt;
                total++; if (cnt != ((len == 0) ? 1 : last_comp + 1)) begin bad++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, cnt, (len == 0) ? 1 : last_comp + 1); end
                if (stall == 0 && gap == 0 && len > 0) begin
                    total++; if (cnt != len + 2) begin bad++; $display("FAIL %s done_latency got=%0d exp=%0d", name, cnt, len + 2); end
                end
                total++; if (words_written !== 16'(len)) begin bad++; $display("FAIL %s done_words got=%0d exp=%0d", name, words_written, len); end
                total++; if (comp != len) begin bad++; $display("FAIL %s done_writes got=%0d exp=%0d", name, comp, len); end
            end

            if (avm_write) hi_cycles++;
            held = avm_write && avm_waitrequest;
            held_addr = avm_address;
            held_data = avm_writedata;

            if (st_valid && st_ready) begin
                src_idx++;
                gap_cnt = gap;
            end else if (gap_cnt > 0) begin
                gap_cnt--;
            end

            if (avm_write) begin
                if (!avm_waitrequest) begin
                    exp_addr = base + 32'(4 * comp);
                    total++;
                    if (comp >= len) begin
                        bad++;
                        $display("FAIL %s extra_write got=%0d exp=%0d", name, comp + 1, len);
                    end else if (avm_address !== exp_addr || avm_writedata !== src[comp]) begin
                        bad++;
                        $display("FAIL %s write%0d got=%h/%h exp=%h/%h", name, comp, avm_address, avm_writedata, exp_addr, src[comp]);
                    end
                    if (stall == 0 && gap == 0) begin
                        total++; if (cnt != comp + 2) begin bad++; $display("FAIL %s write%0d_cycle got=%0d exp=%0d", name, comp, cnt, comp + 2); end
                    end
                    comp++;
                    wait_cnt = 0;
                    last_comp = cnt;
                    if (abort_after >= 0 && comp == abort_after) abort_now = 1;
                end else begin
                    wait_cnt++;
                end
            end
            @(posedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_nominal();
        run_cmd(32'h0000_1000, 4, 0, 0, 0, -1, 1, 32'hA0, "nominal");
    endtask

    task automatic test_stall();
        run_cmd(32'h0000_3000, 3, 2, 0, 0, -1, 0, 32'h0, "stall");
    endtask

    task automatic test_starvation();
        run_cmd(32'h0000_4000, 2, 0, 3, 0, -1, 0, 32'h0, "starve");
    endtask

    task automatic test_zero_unaligned();
        run_cmd(32'h0000_2003, 0, 0, 0, 0, -1, 0, 32'h0, "zero_len");
        run_cmd(32'h0000_2003, 1, 0, 0, 0, -1, 0, 32'h0, "unaligned");
    endtask

    task automatic test_wrap_busy();
        run_cmd(32'hFFFF_FFFC, 2, 0, 0, 1, -1, 0, 32'h0, "wrap_hold");
    endtask

    task automatic test_reset_mid();
        run_cmd(32'h0000_5000, 5, 0, 0, 0, 2, 0, 32'h0, "reset_mid");
        run_cmd(32'h0000_6000, 1, 0, 0, 0, -1, 0, 32'h0, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            run_cmd($urandom, int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1, 0, 32'h0, "random");
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_nominal();
        test_stall();
        test_starvation();
        test_zero_unaligned();
        test_wrap_busy();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
